// File: rtl/bmm150_ctrl_if.sv
// Single-byte register transaction bus between the sequencer and the BMM150 SPI master.
interface bmm150_ctrl_if;
  logic       spi_start;
  logic       spi_rw;
  logic [6:0] spi_reg_addr;
  logic [7:0] spi_tx_data;
  logic [7:0] spi_rx_data;
  logic       spi_busy;
  logic       spi_done;

  // Sequencer side: requests transactions, receives completion and read data.
  modport master (
    output spi_start, spi_rw, spi_reg_addr, spi_tx_data,
    input  spi_rx_data, spi_busy, spi_done
  );

  // SPI master side.
  modport slave (
    input  spi_start, spi_rw, spi_reg_addr, spi_tx_data,
    output spi_rx_data, spi_busy, spi_done
  );
endinterface

// File: rtl/bmm150_ctrl.sv
// BMM150 sequencer: power-up, chip-ID check, normal mode, then periodic
// 8-byte data bursts assembled into sign/zero-extended X/Y/Z/RHALL words.
module bmm150_ctrl #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned POWERUP_US = 3000,
  parameter int unsigned SAMPLE_HZ  = 10,
  parameter logic [7:0]  CHIP_ID    = 8'h32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  bmm150_ctrl_if.master spi,
  output logic [15:0]   mag_x,
  output logic [15:0]   mag_y,
  output logic [15:0]   mag_z,
  output logic [15:0]   rhall,
  output logic          data_valid,
  output logic          init_done,
  output logic          id_err
);

  localparam int unsigned POWERUP_CYCLES = (CLK_HZ / 1_000_000) * POWERUP_US;
  localparam int unsigned PERIOD_CYCLES  = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned MAX_CYCLES     = (POWERUP_CYCLES > PERIOD_CYCLES) ?
                                           POWERUP_CYCLES : PERIOD_CYCLES;
  localparam int unsigned CNT_W          = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, PWR_ON, PWR_WAIT, CHK_ID, SET_MODE,
    SAMPLE_WAIT, READ_BURST, PUBLISH, ERROR
  } state_t;

  state_t           state_q, state_d;
  logic             pending_q, pending_d;   // 0 = ISSUE substate, 1 = WAIT substate
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       buf_q [8];
  logic             buf_we;

  logic             start_q, start_d;
  logic             rw_q, rw_d;
  logic [6:0]       addr_q, addr_d;
  logic [7:0]       tx_q, tx_d;
  logic [15:0]      mag_x_q, mag_x_d, mag_y_q, mag_y_d;
  logic [15:0]      mag_z_q, mag_z_d, rhall_q, rhall_d;
  logic             valid_q, valid_d;
  logic             init_q, init_d;
  logic             id_err_q, id_err_d;

  logic             op_rw;
  logic [6:0]       op_addr;
  logic [7:0]       op_tx;

  logic [15:0]      asm_x, asm_y, asm_z, asm_rhall;

  // Output word assembly from the burst buffer.
  assign asm_x     = {{3{buf_q[1][7]}}, buf_q[1], buf_q[0][7:3]};
  assign asm_y     = {{3{buf_q[3][7]}}, buf_q[3], buf_q[2][7:3]};
  assign asm_z     = {buf_q[5][7], buf_q[5], buf_q[4][7:1]};
  assign asm_rhall = {2'b00, buf_q[7], buf_q[6][7:2]};

  assign spi.spi_start    = start_q;
  assign spi.spi_rw       = rw_q;
  assign spi.spi_reg_addr = addr_q;
  assign spi.spi_tx_data  = tx_q;
  assign mag_x            = mag_x_q;
  assign mag_y            = mag_y_q;
  assign mag_z            = mag_z_q;
  assign rhall            = rhall_q;
  assign data_valid       = valid_q;
  assign init_done        = init_q;
  assign id_err           = id_err_q;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      for (int i = 0; i < 8; i++) buf_q[i] <= '0;
      start_q   <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      tx_q      <= '0;
      mag_x_q   <= '0;
      mag_y_q   <= '0;
      mag_z_q   <= '0;
      rhall_q   <= '0;
      valid_q   <= 1'b0;
      init_q    <= 1'b0;
      id_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      if (buf_we) buf_q[idx_q] <= spi.spi_rx_data;
      start_q   <= start_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      mag_x_q   <= mag_x_d;
      mag_y_q   <= mag_y_d;
      mag_z_q   <= mag_z_d;
      rhall_q   <= rhall_d;
      valid_q   <= valid_d;
      init_q    <= init_d;
      id_err_q  <= id_err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    buf_we    = 1'b0;
    start_d   = 1'b0;
    rw_d      = rw_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    mag_x_d   = mag_x_q;
    mag_y_d   = mag_y_q;
    mag_z_d   = mag_z_q;
    rhall_d   = rhall_q;
    valid_d   = 1'b0;
    init_d    = init_q;
    id_err_d  = id_err_q;
    op_rw     = 1'b0;
    op_addr   = '0;
    op_tx     = '0;

    // Register transaction owned by each SPI state.
    case (state_q)
      PWR_ON:     begin op_rw = 1'b0; op_addr = 7'h4B; op_tx = 8'h01; end
      CHK_ID:     begin op_rw = 1'b1; op_addr = 7'h40; end
      SET_MODE:   begin op_rw = 1'b0; op_addr = 7'h4C; op_tx = 8'h00; end
      READ_BURST: begin op_rw = 1'b1; op_addr = 7'h42 + {4'b0000, idx_q}; end
      default:    ;
    endcase

    case (state_q)
      IDLE: begin
        pending_d = 1'b0;
        if (enable) state_d = PWR_ON;
      end
      PWR_WAIT: begin
        if (!enable) state_d = IDLE;
        else if (cnt_q == PWR_LAST) state_d = CHK_ID;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      SAMPLE_WAIT: begin
        if (!enable) state_d = IDLE;
        else if (cnt_q == PER_LAST) begin
          state_d = READ_BURST;
          idx_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      PUBLISH: begin
        if (!enable) state_d = IDLE;
        else begin
          if (buf_q[6][0]) begin
            mag_x_d = asm_x;
            mag_y_d = asm_y;
            mag_z_d = asm_z;
            rhall_d = asm_rhall;
            valid_d = 1'b1;
          end
          state_d = SAMPLE_WAIT;
          cnt_d   = '0;
        end
      end
      ERROR: ;
      default: begin
        // Shared ISSUE/WAIT handling for PWR_ON, CHK_ID, SET_MODE, READ_BURST.
        if (!pending_q) begin
          if (!enable) state_d = IDLE;
          else if (!spi.spi_busy) begin
            start_d   = 1'b1;
            rw_d      = op_rw;
            addr_d    = op_addr;
            tx_d      = op_tx;
            pending_d = 1'b1;
          end
        end else if (spi.spi_done) begin
          pending_d = 1'b0;
          if (!enable) state_d = IDLE;
          else begin
            case (state_q)
              PWR_ON: begin
                state_d = PWR_WAIT;
                cnt_d   = '0;
              end
              CHK_ID: begin
                if (spi.spi_rx_data == CHIP_ID) state_d = SET_MODE;
                else begin
                  id_err_d = 1'b1;
                  state_d  = ERROR;
                end
              end
              SET_MODE: begin
                init_d  = 1'b1;
                state_d = SAMPLE_WAIT;
                cnt_d   = '0;
              end
              READ_BURST: begin
                buf_we = 1'b1;
                if (idx_q == 3'd7) state_d = PUBLISH;
                else idx_d = idx_q + 3'd1;
              end
              default: ;
            endcase
          end
        end
      end
    endcase

    // Any return to IDLE drops the configured flag.
    if (state_d == IDLE) init_d = 1'b0;
  end

endmodule

// File: tb/tb_bmm150_ctrl.sv
// Bench for bmm150_ctrl: behavioural SPI master with a register map,
// transaction and sample scoreboards, one task per scenario.
module tb_bmm150_ctrl;

  localparam int unsigned CLK_HZ     = 1_000_000;
  localparam int unsigned POWERUP_US = 10;
  localparam int unsigned SAMPLE_HZ  = 100_000;
  localparam int POWERUP_CYCLES = 10;
  localparam int PERIOD_CYCLES  = 10;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] tx;
  } txn_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [15:0] r;
  } mag_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] mag_x, mag_y, mag_z, rhall;
  logic        data_valid, init_done, id_err;

  bmm150_ctrl_if spi_bus ();

  bmm150_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .POWERUP_US(POWERUP_US),
    .SAMPLE_HZ (SAMPLE_HZ),
    .CHIP_ID   (8'h32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .spi       (spi_bus),
    .mag_x     (mag_x),
    .mag_y     (mag_y),
    .mag_z     (mag_z),
    .rhall     (rhall),
    .data_valid(data_valid),
    .init_done (init_done),
    .id_err    (id_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_done;

  txn_t exp_q[$];
  mag_t mag_q[$];

  // Sensor register map and SPI master model (fixed 3-cycle busy).
  logic [7:0] regs [128];
  logic       m_busy, m_done, force_busy;
  logic [7:0] m_rx;
  int         m_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_rx   <= 8'h00;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_rx   <= spi_bus.spi_rw ? regs[spi_bus.spi_reg_addr] : 8'h00;
      end else m_cnt <= m_cnt - 1;
    end else if (spi_bus.spi_start === 1'b1) begin
      m_busy <= 1'b1;
      m_cnt  <= 2;
    end
  end

  assign spi_bus.spi_busy    = m_busy | force_busy;
  assign spi_bus.spi_done    = m_done;
  assign spi_bus.spi_rx_data = m_rx;

  task automatic wait_start(input int limit, output txn_t t, output int c, output bit ok);
    ok = 1'b0;
    t  = '0;
    c  = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (spi_bus.spi_start === 1'b1) begin
        t  = {spi_bus.spi_rw, spi_bus.spi_reg_addr, spi_bus.spi_tx_data};
        c  = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int limit, output int c, output bit ok);
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (spi_bus.spi_done === 1'b1) begin
        c  = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    force_busy = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({spi_bus.spi_start, spi_bus.spi_rw, spi_bus.spi_reg_addr, spi_bus.spi_tx_data} !== 17'h0) begin
      n_err++;
      $display("FAIL reset_spi: got %h expected 00000",
               {spi_bus.spi_start, spi_bus.spi_rw, spi_bus.spi_reg_addr, spi_bus.spi_tx_data});
    end
    n_cmp++;
    if ({mag_x, mag_y, mag_z, rhall} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_mag: got %h expected 0", {mag_x, mag_y, mag_z, rhall});
    end
    n_cmp++;
    if ({data_valid, init_done, id_err} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 000", {data_valid, init_done, id_err});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_init();
    txn_t t, e;
    int c, d, prev_done;
    bit ok, okd;
    prev_done = 0;
    exp_q.push_back({1'b0, 7'h4B, 8'h01});
    exp_q.push_back({1'b1, 7'h40, 8'h00});
    exp_q.push_back({1'b0, 7'h4C, 8'h00});
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_start(100, t, c, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || t !== e) begin
        n_err++;
        $display("FAIL init_txn%0d: got %h (seen=%0d) expected %h", k, t, ok, e);
      end
      if (k == 1) begin
        n_cmp++;
        if (c - prev_done != POWERUP_CYCLES + 2) begin
          n_err++;
          $display("FAIL powerup_gap: got %0d expected %0d", c - prev_done, POWERUP_CYCLES + 2);
        end
      end
      wait_done(50, d, okd);
      prev_done = d;
      if (k == 2) begin
        n_cmp++;
        if (!okd || init_done !== 1'b0) begin
          n_err++;
          $display("FAIL init_done_early: got %b (done=%0d) expected 0", init_done, okd);
        end
        @(negedge clk);
        n_cmp++;
        if (init_done !== 1'b1) begin
          n_err++;
          $display("FAIL init_done_rise: got %b expected 1", init_done);
        end
      end
    end
    last_done = prev_done;
  endtask

  task automatic test_burst();
    txn_t t, e;
    mag_t m;
    int c, d, vc;
    bit ok, okd, found;
    d = 0;
    for (int k = 0; k < 8; k++) exp_q.push_back({1'b1, 7'(7'h42 + k), 8'h00});
    mag_q.push_back({16'hFFFF, 16'h0001, 16'h3FFF, 16'h2001});
    for (int k = 0; k < 8; k++) begin
      wait_start(100, t, c, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || t !== e) begin
        n_err++;
        $display("FAIL burst_txn%0d: got %h (seen=%0d) expected %h", k, t, ok, e);
      end
      if (k == 0) begin
        n_cmp++;
        if (c - last_done != PERIOD_CYCLES + 2) begin
          n_err++;
          $display("FAIL first_period: got %0d expected %0d", c - last_done, PERIOD_CYCLES + 2);
        end
      end
      wait_done(50, d, okd);
    end
    found = 1'b0;
    vc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        found = 1'b1;
        vc = cyc;
        break;
      end
    end
    m = mag_q.pop_front();
    n_cmp++;
    if (!found || vc - d != 2) begin
      n_err++;
      $display("FAIL valid_latency: got %0d (seen=%0d) expected 2", vc - d, found);
    end
    n_cmp++;
    if ({mag_x, mag_y, mag_z, rhall} !== m) begin
      n_err++;
      $display("FAIL burst_data: got %h expected %h", {mag_x, mag_y, mag_z, rhall}, m);
    end
    @(negedge clk);
    n_cmp++;
    if (data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL valid_width: got %b expected 0", data_valid);
    end
    last_done = d;
  endtask

  task automatic test_drdy0();
    txn_t t;
    int c, d, nv;
    bit ok, okd;
    logic [63:0] held;
    d = 0;
    held = {16'hFFFF, 16'h0001, 16'h3FFF, 16'h2001};
    regs[7'h48] = 8'h04;
    for (int k = 0; k < 8; k++) begin
      wait_start(100, t, c, ok);
      if (k == 0) begin
        n_cmp++;
        if (!ok || c - last_done != PERIOD_CYCLES + 3) begin
          n_err++;
          $display("FAIL burst_period: got %0d expected %0d", c - last_done, PERIOD_CYCLES + 3);
        end
      end
      wait_done(50, d, okd);
    end
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (data_valid === 1'b1) nv++;
    end
    n_cmp++;
    if (nv != 0) begin
      n_err++;
      $display("FAIL drdy0_valid: got %0d strobes expected 0", nv);
    end
    n_cmp++;
    if ({mag_x, mag_y, mag_z, rhall} !== held) begin
      n_err++;
      $display("FAIL drdy0_hold: got %h expected %h", {mag_x, mag_y, mag_z, rhall}, held);
    end
    regs[7'h48] = 8'h05;
    wait_start(40, t, c, ok);
    n_cmp++;
    if (!ok || c - d != PERIOD_CYCLES + 3 || t !== {1'b1, 7'h42, 8'h00}) begin
      n_err++;
      $display("FAIL drdy0_next_burst: got gap %0d txn %h expected gap %0d txn %h",
               c - d, t, PERIOD_CYCLES + 3, {1'b1, 7'h42, 8'h00});
    end
  endtask

  task automatic test_enable_drop();
    txn_t t;
    int c, d, ns, nv;
    bit ok, okd, hit;
    hit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wait_start(60, t, c, ok);
      if (ok && t.addr == 7'h45) begin
        hit = 1'b1;
        break;
      end
    end
    enable = 1'b0;
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL drop_find_45: got addr %h expected 45", t.addr);
    end
    wait_done(50, d, okd);
    n_cmp++;
    if (!okd) begin
      n_err++;
      $display("FAIL drop_completes: got done=%0d expected 1", okd);
    end
    ns = 0;
    nv = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (spi_bus.spi_start === 1'b1) ns++;
      if (data_valid === 1'b1) nv++;
    end
    n_cmp++;
    if (ns != 0 || nv != 0) begin
      n_err++;
      $display("FAIL drop_quiet: got starts=%0d valids=%0d expected 0/0", ns, nv);
    end
    n_cmp++;
    if (init_done !== 1'b0) begin
      n_err++;
      $display("FAIL drop_init_done: got %b expected 0", init_done);
    end
  endtask

  task automatic test_busy_handshake();
    txn_t t;
    int c, ns, bad;
    bit ok, seen;
    exp_q.push_back({1'b0, 7'h4B, 8'h01});
    force_busy = 1'b1;
    enable = 1'b1;
    ns = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (spi_bus.spi_start === 1'b1) ns++;
    end
    n_cmp++;
    if (ns != 0) begin
      n_err++;
      $display("FAIL busy_hold: got %0d starts expected 0", ns);
    end
    force_busy = 1'b0;
    wait_start(3, t, c, ok);
    n_cmp++;
    if (!ok || t !== exp_q[0]) begin
      n_err++;
      $display("FAIL reenable_txn: got %h (seen=%0d) expected %h", t, ok, exp_q[0]);
    end
    bad = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if ({spi_bus.spi_rw, spi_bus.spi_reg_addr, spi_bus.spi_tx_data} !== exp_q[0]) bad++;
      if (spi_bus.spi_start === 1'b1) bad++;
      if (spi_bus.spi_done === 1'b1) seen = 1'b1;
    end
    void'(exp_q.pop_front());
    n_cmp++;
    if (!seen || bad != 0) begin
      n_err++;
      $display("FAIL addr_stable: got %0d unstable cycles (done=%0d) expected 0", bad, seen);
    end
  endtask

  task automatic test_id_mismatch();
    txn_t t;
    int c, d, ns;
    bit ok, okd;
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    regs[7'h40] = 8'h31;
    enable = 1'b1;
    exp_q.push_back({1'b0, 7'h4B, 8'h01});
    exp_q.push_back({1'b1, 7'h40, 8'h00});
    for (int k = 0; k < 2; k++) begin
      wait_start(100, t, c, ok);
      n_cmp++;
      if (!ok || t !== exp_q[0]) begin
        n_err++;
        $display("FAIL idchk_txn%0d: got %h (seen=%0d) expected %h", k, t, ok, exp_q[0]);
      end
      void'(exp_q.pop_front());
      wait_done(50, d, okd);
    end
    ns = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (spi_bus.spi_start === 1'b1) ns++;
    end
    n_cmp++;
    if (ns != 0) begin
      n_err++;
      $display("FAIL error_quiet: got %0d starts expected 0", ns);
    end
    n_cmp++;
    if (id_err !== 1'b1 || init_done !== 1'b0) begin
      n_err++;
      $display("FAIL id_err_flags: got id_err=%b init_done=%b expected 1/0", id_err, init_done);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    regs[7'h40] = 8'h32;
    regs[7'h42] = 8'hF8;
    regs[7'h43] = 8'hFF;
    regs[7'h44] = 8'h08;
    regs[7'h45] = 8'h00;
    regs[7'h46] = 8'hFE;
    regs[7'h47] = 8'h7F;
    regs[7'h48] = 8'h05;
    regs[7'h49] = 8'h80;
    last_done = 0;
    test_reset();
    test_init();
    test_burst();
    test_drdy0();
    test_enable_drop();
    test_busy_handshake();
    test_id_mismatch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
